// File: rtl/fir_decim_fifo.sv
// Decimating output stage for the 8-bit FIR low-pass: keeps every DECIM-th
// valid sample and buffers it in a DEPTH-entry FIFO behind a valid/ready port.
module fir_decim_fifo #(
  parameter int DATA_W = 8,
  parameter int DECIM  = 4,
  parameter int DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    fill,
  output logic                      overflow,
  input  logic                      ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [AW:0]       fill_q, fill_d;
  logic              ovf_q, ovf_d;
  logic              keep, push, pop, full;

  always_comb begin
    full  = (fill_q == (AW+1)'(DEPTH));
    keep  = in_valid && (phase_q == '0);
    pop   = (fill_q != '0) && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push  = keep && (!full || pop);

    phase_d = phase_q;
    if (in_valid)
      phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + 1'b1;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    fill_d = fill_q;
    if (push && !pop)
      fill_d = fill_q + 1'b1;
    else if (pop && !push)
      fill_d = fill_q - 1'b1;

    // A drop outranks a clear request in the same cycle.
    ovf_d = ovf_q;
    if (keep && !push)
      ovf_d = 1'b1;
    else if (ovf_clr)
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push)
      mem_q[wr_ptr_q] <= in_data;
  end

  assign out_valid = (fill_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fill      = fill_q;
  assign overflow  = ovf_q;

endmodule
